// File: rtl/vproc_pkg.sv
// Shared types for the vector FPU result path.
//   fpu_fflags_t : packed IEEE exception flags {NV,DZ,OF,UF,NX}, NX in bit 0.
//   FPU_FFLAGS_W : width of the flag vector.
package vproc_pkg;

    localparam int unsigned FPU_FFLAGS_W = 5;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fpu_fflags_t;

endpackage

// File: rtl/vproc_fpu_resbuf.sv
// Result buffer between the vector FPU pipeline and vreg write-back.
// Small circular FIFO (DEPTH entries, no bypass) that also accumulates
// per-instruction exception flags when VPROC_FPU_FFLAGS_EN is defined.
//
// Ports:
//   clk_i, async_rst_ni            clock, async active-low reset
//   flush_i                        synchronous clear of buffer and flag state
//   in_valid_i / in_ready_o        producer handshake (FPU stage)
//   in_ctrl_i, in_res_i, in_mask_i result beat payload
//   in_status_i                    per-32-bit-lane flags, lane g at [5g+4:5g]
//   in_last_i                      final beat of the instruction
//   out_valid_o / out_ready_i      consumer handshake (write-back)
//   out_ctrl_o, out_res_o, out_mask_o  head entry
//   fflags_valid_o, fflags_o       accumulated flags of the finished instruction
//
// Build option: VPROC_FPU_FFLAGS_EN enables flag accumulation; otherwise the
// flag outputs are tied low and in_status_i / in_last_i are ignored.
module vproc_fpu_resbuf
    import vproc_pkg::*;
#(
    parameter int unsigned FPU_OP_W = 64,
    parameter type         CTRL_T   = logic,
    parameter int unsigned DEPTH    = 2
) (
    input  logic                           clk_i,
    input  logic                           async_rst_ni,
    input  logic                           flush_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  CTRL_T                          in_ctrl_i,
    input  logic [FPU_OP_W-1:0]            in_res_i,
    input  logic [FPU_OP_W/8-1:0]          in_mask_i,
    input  logic [5*(FPU_OP_W/32)-1:0]     in_status_i,
    input  logic                           in_last_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output CTRL_T                          out_ctrl_o,
    output logic [FPU_OP_W-1:0]            out_res_o,
    output logic [FPU_OP_W/8-1:0]          out_mask_o,
    output logic                           fflags_valid_o,
    output logic [FPU_FFLAGS_W-1:0]        fflags_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LANES = FPU_OP_W / 32;
    localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];

    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   count;
    logic             push, pop;

    CTRL_T                 ctrl_q [DEPTH];
    logic [FPU_OP_W-1:0]   res_q  [DEPTH];
    logic [FPU_OP_W/8-1:0] mask_q [DEPTH];

    // Both handshakes depend only on registered count, so out_ready_i never
    // reaches in_ready_o combinationally.
    assign in_ready_o  = (count < DEPTH_C);
    assign out_valid_o = (count != '0);
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    assign out_ctrl_o = ctrl_q[rd_ptr];
    assign out_res_o  = res_q[rd_ptr];
    assign out_mask_o = mask_q[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            ctrl_q[wr_ptr] <= in_ctrl_i;
            res_q[wr_ptr]  <= in_res_i;
            mask_q[wr_ptr] <= in_mask_i;
        end
    end

`ifdef VPROC_FPU_FFLAGS_EN
    logic [FPU_FFLAGS_W-1:0] beat_flags;
    logic [FPU_FFLAGS_W-1:0] acc_q;
    fpu_fflags_t             fflags_q;
    logic                    fflags_vld_q;

    always_comb begin
        beat_flags = '0;
        for (int g = 0; g < int'(LANES); g++)
            beat_flags = beat_flags | in_status_i[5*g +: 5];
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            acc_q        <= '0;
            fflags_q     <= '0;
            fflags_vld_q <= 1'b0;
        end else if (flush_i) begin
            acc_q        <= '0;
            fflags_vld_q <= 1'b0;
        end else begin
            fflags_vld_q <= 1'b0;
            if (push) begin
                if (in_last_i) begin
                    // Publish the finished instruction and restart accumulation.
                    fflags_q     <= acc_q | beat_flags;
                    fflags_vld_q <= 1'b1;
                    acc_q        <= '0;
                end else begin
                    acc_q <= acc_q | beat_flags;
                end
            end
        end
    end

    assign fflags_valid_o = fflags_vld_q;
    assign fflags_o       = fflags_q;
`else
    logic unused_flag_inputs;
    assign unused_flag_inputs = ^{in_status_i, in_last_i};
    assign fflags_valid_o = 1'b0;
    assign fflags_o       = '0;
`endif

endmodule
